// File: rtl/biquad_cmd_framer_if.sv
// biquad_cmd_framer_if: host request, UART TX write and UART RX read signals of the command framer
interface biquad_cmd_framer_if;
  logic        coef_start;
  logic [95:0] coef_bus;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample;
  logic        finish;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;
  logic [2:0]  s;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        y_valid;
  logic [15:0] y;
  modport slave (
    input  coef_start, coef_bus, sample_valid, sample, finish, tx_full, rx_empty, r_data,
    output sample_ready, wr_uart, w_data, busy, s, rd_uart, y_valid, y
  );
  modport master (
    output coef_start, coef_bus, sample_valid, sample, finish, tx_full, rx_empty, r_data,
    input  sample_ready, wr_uart, w_data, busy, s, rd_uart, y_valid, y
  );
endinterface

// File: rtl/biquad_cmd_framer.sv
// biquad_cmd_framer: frames coef/data/done commands into UART TX bytes for the biquad link.
// Define RX_COLLECT_EN to pair returned RX bytes into 16-bit filter outputs on y/y_valid.
module biquad_cmd_framer #(
  parameter logic [31:0] TAG_COEF = 32'h636F6566,
  parameter logic [31:0] TAG_DATA = 32'h64617461,
  parameter logic [31:0] TAG_DONE = 32'h646F6E65,
  parameter int unsigned GAP      = 0
) (
  input logic clk,
  input logic reset,
  biquad_cmd_framer_if.slave cmd
);
  typedef enum logic [2:0] {IDLE = 3'd0, TAG = 3'd1, COEF = 3'd2, DWAIT = 3'd3, SAMP = 3'd4, DONE_TAG = 3'd5} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_idx;
  logic [7:0]  r_gap, r_wdata, w_byte;
  logic [95:0] r_coef;
  logic [15:0] r_sample;
  logic        r_tag_data, r_open, r_wr;
  logic        w_accept, w_ready, w_take, w_emit, w_last;
  logic [31:0] w_tag;
  always_comb begin
    w_accept = r_state == IDLE || r_state == DWAIT;
    w_ready  = w_accept && !cmd.finish && !cmd.coef_start && !reset;
    w_take   = w_ready && cmd.sample_valid;
    w_emit   = !w_accept && !cmd.tx_full && r_gap == 8'd0;
    w_tag    = r_state == DONE_TAG ? TAG_DONE : r_tag_data ? TAG_DATA : TAG_COEF;
    w_byte   = r_state == COEF ? r_coef[7'd88 - {r_idx, 3'b000} +: 8] :
               r_state == SAMP ? (r_idx[0] ? r_sample[7:0] : r_sample[15:8]) :
               w_tag[5'd24 - {r_idx[1:0], 3'b000} +: 8];
    w_last   = r_idx == (r_state == COEF ? 4'd11 : r_state == SAMP ? 4'd1 : 4'd3);
    w_next   = r_state;
    if (w_accept)
      w_next = cmd.finish ? DONE_TAG : cmd.coef_start ? TAG : !w_take ? r_state : r_open ? SAMP : TAG;
    else if (w_emit && w_last)
      w_next = r_state == TAG ? (r_tag_data ? SAMP : COEF) : r_state == DONE_TAG ? IDLE : DWAIT;
  end
  // segment transitions share the edge of their last byte, so GAP=0 streams back to back
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_gap      <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_coef     <= '0;
      r_sample   <= '0;
      r_tag_data <= 1'b0;
      r_open     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wr    <= w_emit;
      if (w_emit) begin
        r_wdata <= w_byte;
        r_idx   <= w_last ? 4'd0 : r_idx + 4'd1;
        r_gap   <= 8'(GAP);
      end else if (r_gap != 8'd0)
        r_gap <= r_gap - 8'd1;
      if (w_accept && cmd.finish)
        r_open <= 1'b0;
      else if (w_accept && cmd.coef_start) begin
        r_coef     <= cmd.coef_bus;
        r_tag_data <= 1'b0;
        r_open     <= 1'b1;
      end else if (w_take) begin
        r_sample   <= cmd.sample;
        r_tag_data <= 1'b1;
        r_open     <= 1'b1;
      end
    end
  end
  assign cmd.sample_ready = w_ready;
  assign cmd.wr_uart      = r_wr;
  assign cmd.w_data       = r_wdata;
  assign cmd.busy         = !w_accept;
  assign cmd.s            = r_state;
`ifdef RX_COLLECT_EN
  logic       r_phase, r_yv;
  logic [7:0] r_hi;
  logic [15:0] r_y;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= 1'b0;
      r_yv    <= 1'b0;
      r_hi    <= '0;
      r_y     <= '0;
    end else begin
      r_yv <= 1'b0;
      if (w_accept && (cmd.finish || cmd.coef_start))
        r_phase <= 1'b0;
      else if (!cmd.rx_empty) begin
        if (r_phase) begin
          r_y  <= {r_hi, cmd.r_data};
          r_yv <= 1'b1;
        end else
          r_hi <= cmd.r_data;
        r_phase <= !r_phase;
      end
    end
  end
  assign cmd.rd_uart = !cmd.rx_empty;
  assign cmd.y       = r_y;
  assign cmd.y_valid = r_yv;
`else
  assign cmd.rd_uart = 1'b0;
  assign cmd.y       = '0;
  assign cmd.y_valid = 1'b0;
`endif
endmodule

// File: tb/tb_biquad_cmd_framer.sv
// tb_biquad_cmd_framer: randomized scoreboard bench; byte stream model built from the command rules.
module tb_biquad_cmd_framer;
  localparam logic [31:0] TC = 32'h636F6566, TD = 32'h64617461, TN = 32'h646F6E65;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  biquad_cmd_framer_if m ();
  biquad_cmd_framer_if g ();
  biquad_cmd_framer u_dut (.clk(clk), .reset(reset), .cmd(m.slave));
  biquad_cmd_framer #(.GAP(3)) u_gap (.clk(clk), .reset(reset), .cmd(g.slave));
  int n_cmp = 0, n_bad = 0, gcyc = 0, last_g = -1;
  logic [7:0] q[$], gq[$];
  logic [15:0] yq[$];
  bit open_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  always @(negedge clk) if (m.wr_uart) begin
    if (q.size() == 0) flag("unexpected_byte");
    else chk("tx_byte", m.w_data, q.pop_front());
  end

  always @(negedge clk) if (m.y_valid) begin
    if (yq.size() == 0) flag("unexpected_y");
    else chk("y_value", m.y, yq.pop_front());
  end

  always @(negedge clk) begin
    gcyc++;
    if (g.wr_uart) begin
      if (last_g >= 0) chk("gap_spacing", gcyc - last_g, 4);
      last_g = gcyc;
      if (gq.size() == 0) flag("gap_unexpected_byte");
      else chk("gap_byte", g.w_data, gq.pop_front());
    end
  end

  task automatic exp_tag(input logic [31:0] t);
    for (int i = 0; i < 4; i++) q.push_back(t[31-8*i -: 8]);
  endtask

  task automatic do_coef(input logic [95:0] b);
    m.coef_bus = b;
    m.coef_start = 1'b1;
    exp_tag(TC);
    for (int i = 0; i < 12; i++) q.push_back(b[95-8*i -: 8]);
    open_m = 1'b1;
  endtask

  task automatic do_sample(input logic [15:0] x);
    m.sample = x;
    m.sample_valid = 1'b1;
    if (!open_m) exp_tag(TD);
    q.push_back(x[15:8]);
    q.push_back(x[7:0]);
    open_m = 1'b1;
  endtask

  task automatic do_finish();
    m.finish = 1'b1;
    exp_tag(TN);
    open_m = 1'b0;
  endtask

  // clears pulsed requests, counts cycles spent busy until the framer is back in IDLE/DWAIT
  task automatic run(output int bc, input bit rnd);
    int t;
    t = 0;
    bc = 0;
    do begin
      @(negedge clk);
      m.coef_start = 1'b0;
      m.finish = 1'b0;
      m.sample_valid = 1'b0;
      g.coef_start = 1'b0;
      if (m.busy) bc++;
      m.tx_full = rnd && m.busy && ($urandom_range(0, 3) == 0);
      t++;
    end while (m.busy && t < 3000);
    m.tx_full = 1'b0;
    if (t >= 3000) flag("run_timeout");
  endtask

  task automatic rx_byte(input logic [7:0] b);
    m.r_data = b;
    m.rx_empty = 1'b0;
    @(negedge clk);
    m.rx_empty = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c, k, t;
    logic [95:0] b;
    logic [7:0] held;
    {m.coef_start, m.sample_valid, m.finish, m.tx_full} = '0;
    m.coef_bus = '0;
    m.sample = '0;
`ifdef RX_COLLECT_EN
    m.rx_empty = 1'b1;
`else
    m.rx_empty = 1'b0;
`endif
    m.r_data = 8'h5A;
    {g.coef_start, g.sample_valid, g.finish, g.tx_full} = '0;
    g.coef_bus = '0;
    g.sample = '0;
    g.rx_empty = 1'b1;
    g.r_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_s", m.s, 0);
    chk("rst_wr", m.wr_uart, 0);
    chk("rst_wdata", m.w_data, 0);
    chk("rst_busy", m.busy, 0);
    chk("rst_ready", m.sample_ready, 0);
    chk("rst_y", m.y, 0);
    chk("rst_yvalid", m.y_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", m.sample_ready, 1);
    do_coef(96'h0100_0200_0300_0E00_F100_0200);
    b = {$urandom(), $urandom(), $urandom()};
    g.coef_bus = b;
    g.coef_start = 1'b1;
    for (int i = 0; i < 12; i++) gq.push_back(b[95-8*i -: 8]);
    for (int i = 0; i < 4; i++) gq.push_front(TC[8*i +: 8]);
    run(c, 0);
    chk("coef_cycles", c, 16);
    chk("coef_end_s", m.s, 3);
    chk("dwait_ready", m.sample_ready, 1);
    do_sample(16'h1234);
    run(c, 0);
    chk("samp_cycles", c, 2);
    do_finish();
    run(c, 0);
    chk("done_cycles", c, 4);
    chk("done_s", m.s, 0);
    do_sample(16'hABCD);
    run(c, 0);
    chk("samp_tag_cycles", c, 6);
    do_finish();
    run(c, 0);
    do_coef({$urandom(), $urandom(), $urandom()});
    repeat (7) begin
      @(negedge clk);
      m.coef_start = 1'b0;
    end
    chk("stall_s", m.s, 2);
    m.tx_full = 1'b1;
    held = m.w_data;
    repeat (5) begin
      @(negedge clk);
      chk("stall_wr", m.wr_uart, 0);
      chk("stall_wdata", m.w_data, held);
    end
    m.tx_full = 1'b0;
    run(c, 0);
    chk("stall_rest_cycles", c, 9);
    do_finish();
    m.sample = 16'hBEEF;
    m.sample_valid = 1'b1;
    #1 chk("finish_blocks_ready", m.sample_ready, 0);
    run(c, 0);
    chk("finish_prio_cycles", c, 4);
    chk("finish_prio_s", m.s, 0);
    chk("finish_prio_busy", m.busy, 0);
    do_coef({$urandom(), $urandom(), $urandom()});
    repeat (3) begin
      @(negedge clk);
      m.coef_start = 1'b0;
    end
    m.finish = 1'b1;
    m.sample_valid = 1'b1;
    #1 chk("busy_ready", m.sample_ready, 0);
    run(c, 0);
    chk("ignored_req_cycles", c, 13);
    t = 0;
    while (gq.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("gap_frame_done", gq.size(), 0);
    do_coef({$urandom(), $urandom(), $urandom()});
    k = 0;
    t = 0;
    while (k < 7 && t < 100) begin
      @(negedge clk);
      m.coef_start = 1'b0;
      if (m.wr_uart) k++;
      t++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_wr", m.wr_uart, 0);
    chk("midrst_s", m.s, 0);
    chk("midrst_busy", m.busy, 0);
    q.delete();
    open_m = 1'b0;
    do_sample(16'(($urandom())));
    run(c, 0);
    chk("post_rst_samp_cycles", c, 6);
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 5);
      if (k == 0) do_coef({$urandom(), $urandom(), $urandom()});
      else if (k == 1) do_finish();
      else do_sample(16'($urandom()));
      run(c, 1);
    end
`ifdef RX_COLLECT_EN
    yq.push_back(16'h7FFE);
    yq.push_back(16'h8001);
    rx_byte(8'h7F);
    rx_byte(8'hFE);
    rx_byte(8'h80);
    rx_byte(8'h01);
    rx_byte(8'h11);
    do_finish();
    run(c, 0);
    yq.push_back(16'hA55A);
    rx_byte(8'hA5);
    rx_byte(8'h5A);
    repeat (2) @(negedge clk);
    chk("y_drained", yq.size(), 0);
`else
    chk("rx_off_rd", m.rd_uart, 0);
    chk("rx_off_y", m.y, 0);
    chk("rx_off_yvalid", m.y_valid, 0);
`endif
    repeat (2) @(negedge clk);
    chk("tx_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
